// File: rtl/sine_fx_sequencer.sv
// Sine-ROM sequencer: per-line lookups for two wobble channels plus host lookups
// in idle slots. Sole driver of the shared ROM address; assumes a 1-cycle ROM.
module sine_fx_sequencer #(
    parameter int ROM_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        line_strobe,
    input  logic        ch0_enable,
    input  logic [2:0]  ch0_table,
    input  logic [7:0]  ch0_step,
    input  logic [7:0]  ch0_phase_init,
    input  logic        ch0_phase_load,
    output logic [8:0]  ch0_offset,
    output logic        ch0_valid,
    input  logic        ch1_enable,
    input  logic [2:0]  ch1_table,
    input  logic [7:0]  ch1_step,
    input  logic [7:0]  ch1_phase_init,
    input  logic        ch1_phase_load,
    output logic [8:0]  ch1_offset,
    output logic        ch1_valid,
    input  logic        host_req,
    input  logic [11:0] host_addr,
    output logic [8:0]  host_data,
    output logic        host_ack,
    output logic [11:0] rom_addr,
    input  logic [8:0]  rom_dout,
    output logic        busy,
    output logic        overrun,
    input  logic        overrun_clr
);

    if (ROM_LAT != 1) begin : g_lat_unsupported
        $error("sine_fx_sequencer: only ROM_LAT = 1 is supported");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_C0, S_C1, S_C2, S_H0, S_H1
    } state_t;

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic        ovr_q, ovr_d;
    logic [7:0]  ph0_q, ph0_d, ph1_q, ph1_d;
    logic [11:0] addr_q, addr_d;
    logic        en0_q, en0_d, flat0_q, flat0_d;
    logic        en1_q, en1_d, flat1_q, flat1_d;
    logic [8:0]  off0_q, off0_d, off1_q, off1_d;
    logic        v0_q, v0_d, v1_q, v1_d;
    logic [8:0]  hdata_q, hdata_d;
    logic        ack_q, ack_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            pend_q  <= 1'b0;
            ovr_q   <= 1'b0;
            ph0_q   <= '0;
            ph1_q   <= '0;
            addr_q  <= '0;
            en0_q   <= 1'b0;
            flat0_q <= 1'b0;
            en1_q   <= 1'b0;
            flat1_q <= 1'b0;
            off0_q  <= '0;
            off1_q  <= '0;
            v0_q    <= 1'b0;
            v1_q    <= 1'b0;
            hdata_q <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            ph0_q   <= ph0_d;
            ph1_q   <= ph1_d;
            addr_q  <= addr_d;
            en0_q   <= en0_d;
            flat0_q <= flat0_d;
            en1_q   <= en1_d;
            flat1_q <= flat1_d;
            off0_q  <= off0_d;
            off1_q  <= off1_d;
            v0_q    <= v0_d;
            v1_q    <= v1_d;
            hdata_q <= hdata_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        ph0_d   = ph0_q;
        ph1_d   = ph1_q;
        addr_d  = addr_q;
        en0_d   = en0_q;
        flat0_d = flat0_q;
        en1_d   = en1_q;
        flat1_d = flat1_q;
        off0_d  = off0_q;
        off1_d  = off1_q;
        v0_d    = 1'b0;
        v1_d    = 1'b0;
        hdata_d = hdata_q;
        ack_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (line_strobe || pend_q) begin
                    state_d = S_C0;
                    addr_d  = {1'b0, ch0_table, ph0_q};
                    en0_d   = ch0_enable;
                    flat0_d = (ch0_table == 3'd7);
                    pend_d  = 1'b0;
                end else if (host_req && !ack_q) begin
                    state_d = S_H0;
                    addr_d  = host_addr;
                end
            end
            S_C0: begin
                state_d = S_C1;
                addr_d  = {1'b0, ch1_table, ph1_q};
                en1_d   = ch1_enable;
                flat1_d = (ch1_table == 3'd7);
            end
            // ch0 data arrives; a disabled slot is still consumed so line timing is fixed
            S_C1: begin
                state_d = S_C2;
                if (en0_q) begin
                    v0_d   = 1'b1;
                    off0_d = flat0_q ? 9'd0 : rom_dout - 9'd256;
                    ph0_d  = ph0_q + ch0_step;
                end else begin
                    off0_d = 9'd0;
                end
            end
            S_C2: begin
                state_d = S_IDLE;
                if (en1_q) begin
                    v1_d   = 1'b1;
                    off1_d = flat1_q ? 9'd0 : rom_dout - 9'd256;
                    ph1_d  = ph1_q + ch1_step;
                end else begin
                    off1_d = 9'd0;
                end
            end
            S_H0: state_d = S_H1;
            S_H1: begin
                state_d = S_IDLE;
                hdata_d = rom_dout;
                ack_d   = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase

        // A strobe while busy is remembered once; a second one is lost and flagged.
        if (state_q != S_IDLE && line_strobe) begin
            if (pend_q) ovr_d = 1'b1;
            else        pend_d = 1'b1;
        end
        if (overrun_clr && !(state_q != S_IDLE && line_strobe && pend_q))
            ovr_d = 1'b0;

        if (ch0_phase_load) ph0_d = ch0_phase_init;
        if (ch1_phase_load) ph1_d = ch1_phase_init;
    end

    assign rom_addr   = addr_q;
    assign ch0_offset = off0_q;
    assign ch0_valid  = v0_q;
    assign ch1_offset = off1_q;
    assign ch1_valid  = v1_q;
    assign host_data  = hdata_q;
    assign host_ack   = ack_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = ovr_q;

endmodule

// File: tb/tb_sine_fx_sequencer.sv
// Bench for sine_fx_sequencer: event-scheduled reference model checked every
// cycle, plus directed scenarios with hand-computed ROM lookups.
module tb_sine_fx_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        line_strobe;
    logic        ch0_enable, ch0_phase_load, ch0_valid;
    logic [2:0]  ch0_table;
    logic [7:0]  ch0_step, ch0_phase_init;
    logic [8:0]  ch0_offset;
    logic        ch1_enable, ch1_phase_load, ch1_valid;
    logic [2:0]  ch1_table;
    logic [7:0]  ch1_step, ch1_phase_init;
    logic [8:0]  ch1_offset;
    logic        host_req, host_ack;
    logic [11:0] host_addr;
    logic [8:0]  host_data;
    logic [11:0] rom_addr;
    logic [8:0]  rom_dout = '0;
    logic        busy, overrun, overrun_clr;

    int tests = 0;
    int fails = 0;
    logic chk_on = 1'b0;

    sine_fx_sequencer #(.ROM_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n), .line_strobe(line_strobe),
        .ch0_enable(ch0_enable), .ch0_table(ch0_table), .ch0_step(ch0_step),
        .ch0_phase_init(ch0_phase_init), .ch0_phase_load(ch0_phase_load),
        .ch0_offset(ch0_offset), .ch0_valid(ch0_valid),
        .ch1_enable(ch1_enable), .ch1_table(ch1_table), .ch1_step(ch1_step),
        .ch1_phase_init(ch1_phase_init), .ch1_phase_load(ch1_phase_load),
        .ch1_offset(ch1_offset), .ch1_valid(ch1_valid),
        .host_req(host_req), .host_addr(host_addr), .host_data(host_data),
        .host_ack(host_ack), .rom_addr(rom_addr), .rom_dout(rom_dout),
        .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr)
    );

    always #5 clk = ~clk;

    // ROM contents: ROM[a] = (7a + 3) mod 512, registered read
    logic [8:0] rom_mem [0:4095];
    initial for (int a = 0; a < 4096; a++) rom_mem[a] = 9'((a * 7 + 3) % 512);
    always @(posedge clk) rom_dout <= rom_mem[rom_addr];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: accepting a line schedules absolute edge numbers for the
    // ch1 issue and the two captures; a host access schedules its ack.
    int          n = 0, busy_left = 0;
    int          ev_c1 = -1, ev_k0 = -1, ev_k1 = -1, ev_ha = -1;
    logic        m_pend = 0, m_ovr = 0, m_en0 = 0, m_en1 = 0, m_f0 = 0, m_f1 = 0;
    logic [7:0]  m_ph0 = 0, m_ph1 = 0;
    logic [11:0] m_a0 = 0, m_a1 = 0, m_ha = 0, e_addr = 0;
    logic [8:0]  e_off0 = 0, e_off1 = 0, e_hd = 0;
    logic        e_v0 = 0, e_v1 = 0, e_ack = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n = 0; busy_left = 0;
            ev_c1 = -1; ev_k0 = -1; ev_k1 = -1; ev_ha = -1;
            m_pend = 0; m_ovr = 0; m_ph0 = 0; m_ph1 = 0;
            e_addr = 0; e_off0 = 0; e_off1 = 0; e_hd = 0;
            e_v0 = 0; e_v1 = 0; e_ack = 0;
        end else begin
            logic idle, lost;
            logic [7:0] np0, np1;
            n++;
            idle = (busy_left == 0);
            np0 = m_ph0;
            np1 = m_ph1;
            e_v0 = 0;
            e_v1 = 0;
            if (n == ev_k0) begin
                e_v0   = m_en0;
                e_off0 = (!m_en0 || m_f0) ? 9'd0 : 9'(rom_mem[m_a0] - 9'd256);
                if (m_en0) np0 = m_ph0 + ch0_step;
            end
            if (n == ev_k1) begin
                e_v1   = m_en1;
                e_off1 = (!m_en1 || m_f1) ? 9'd0 : 9'(rom_mem[m_a1] - 9'd256);
                if (m_en1) np1 = m_ph1 + ch1_step;
            end
            if (ch0_phase_load) np0 = ch0_phase_init;
            if (ch1_phase_load) np1 = ch1_phase_init;

            if (idle && (line_strobe || m_pend)) begin
                e_addr = {1'b0, ch0_table, m_ph0};
                m_a0 = e_addr; m_en0 = ch0_enable; m_f0 = (ch0_table == 3'd7);
                ev_c1 = n + 1; ev_k0 = n + 2; ev_k1 = n + 3;
                busy_left = 3; m_pend = 0;
            end else if (idle && host_req && !e_ack) begin
                e_addr = host_addr; m_ha = host_addr;
                ev_ha = n + 2; busy_left = 2;
            end else if (busy_left > 0) begin
                busy_left--;
            end
            if (n == ev_c1) begin
                e_addr = {1'b0, ch1_table, m_ph1};
                m_a1 = e_addr; m_en1 = ch1_enable; m_f1 = (ch1_table == 3'd7);
            end

            lost = 0;
            if (!idle && line_strobe) begin
                if (m_pend) lost = 1;
                else        m_pend = 1;
            end
            if (lost) m_ovr = 1;
            else if (overrun_clr) m_ovr = 0;

            e_ack = (n == ev_ha);
            if (e_ack) e_hd = rom_mem[m_ha];
            m_ph0 = np0;
            m_ph1 = np1;
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            chk("rom_addr",   32'(rom_addr),   32'(e_addr));
            chk("ch0_valid",  32'(ch0_valid),  32'(e_v0));
            chk("ch0_offset", 32'(ch0_offset), 32'(e_off0));
            chk("ch1_valid",  32'(ch1_valid),  32'(e_v1));
            chk("ch1_offset", 32'(ch1_offset), 32'(e_off1));
            chk("host_ack",   32'(host_ack),   32'(e_ack));
            chk("host_data",  32'(host_data),  32'(e_hd));
            chk("busy",       32'(busy),       32'(busy_left != 0));
            chk("overrun",    32'(overrun),    32'(m_ovr));
        end
    end

    task automatic tick(input int k = 1);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish by 200000");
        $fatal(1);
    end

    initial begin
        rst_n = 1; line_strobe = 0; overrun_clr = 0;
        ch0_enable = 0; ch0_table = 0; ch0_step = 0; ch0_phase_init = 0; ch0_phase_load = 0;
        ch1_enable = 0; ch1_table = 0; ch1_step = 0; ch1_phase_init = 0; ch1_phase_load = 0;
        host_req = 0; host_addr = 0;
        #3 rst_n = 0;
        #1 chk_on = 1;
        tick(2);
        chk("rst busy", 32'(busy), 0);
        chk("rst rom_addr", 32'(rom_addr), 0);
        rst_n = 1;
        tick(2);

        // ch0 table 0, phase 64, step 4
        ch0_enable = 1; ch0_table = 0; ch0_phase_init = 8'd64; ch0_step = 8'd4; ch0_phase_load = 1;
        tick(); ch0_phase_load = 0;
        line_strobe = 1; tick(); line_strobe = 0;
        chk("t1 addr E0", 32'(rom_addr), 32'h040);
        chk("t1 busy", 32'(busy), 1);
        tick(2);
        chk("t1 ch0_valid E2", 32'(ch0_valid), 1);
        chk("t1 ch0_offset", 32'(ch0_offset), 32'h0C3);
        chk("model ch0_offset", 32'(e_off0), 32'h0C3);
        tick();
        chk("t1 idle E3", 32'(busy), 0);
        tick(2);
        line_strobe = 1; tick(); line_strobe = 0;
        chk("t1 phase 68", 32'(rom_addr), 32'h044);
        tick(5);

        // ch1 table 3, phase 0xFE, step 5, strobes 10 cycles apart
        ch0_enable = 0;
        ch1_enable = 1; ch1_table = 3; ch1_phase_init = 8'hFE; ch1_step = 8'd5; ch1_phase_load = 1;
        tick(); ch1_phase_load = 0;
        line_strobe = 1; tick(); line_strobe = 0;
        tick();
        chk("t2 addr 3FE", 32'(rom_addr), 32'h3FE);
        tick();
        chk("t2 ch0 forced 0", 32'(ch0_offset), 0);
        tick();
        chk("t2 ch1_valid E3", 32'(ch1_valid), 1);
        chk("t2 ch1_offset a", 32'(ch1_offset), 32'h0F5);
        tick(6);
        line_strobe = 1; tick(); line_strobe = 0;
        tick();
        chk("t2 addr 303", 32'(rom_addr), 32'h303);
        tick(2);
        chk("t2 ch1_offset b", 32'(ch1_offset), 32'h018);
        tick(3);

        // ch0 disabled, ch1 flat table
        ch1_table = 7;
        line_strobe = 1; tick(); line_strobe = 0;
        tick();
        chk("t3 addr ch1 flat", 32'(rom_addr), 32'h708);
        tick();
        chk("t3 busy E2", 32'(busy), 1);
        tick();
        chk("t3 ch1_valid", 32'(ch1_valid), 1);
        chk("t3 ch1_offset", 32'(ch1_offset), 0);
        chk("t3 idle E3", 32'(busy), 0);
        tick(3);

        // host lookup with a strobe landing during H0
        host_req = 1; host_addr = 12'h6FF;
        tick();
        chk("t4 host addr", 32'(rom_addr), 32'h6FF);
        line_strobe = 1; tick(); line_strobe = 0;
        tick();
        chk("t4 host_ack", 32'(host_ack), 1);
        chk("t4 host_data", 32'(host_data), 32'h0FC);
        host_req = 0;
        tick();
        chk("t4 C0 after H1", 32'(rom_addr), 32'h048);
        chk("t4 no overrun", 32'(overrun), 0);
        tick(6);

        // overrun: three consecutive strobes, clear, coincident clear
        line_strobe = 1; tick(3); line_strobe = 0;
        chk("t5 overrun set", 32'(overrun), 1);
        tick(8);
        line_strobe = 1; tick(2);
        overrun_clr = 1; tick();
        line_strobe = 0; overrun_clr = 0;
        chk("t5 clr+set keeps", 32'(overrun), 1);
        tick(8);
        overrun_clr = 1; tick(); overrun_clr = 0;
        chk("t5 overrun cleared", 32'(overrun), 0);
        tick(2);

        // reset during C1
        ch0_enable = 1; ch0_table = 2; ch1_enable = 1; ch1_table = 1;
        line_strobe = 1; tick(); line_strobe = 0;
        tick();
        rst_n = 0;
        #1;
        chk("t6 rst rom_addr", 32'(rom_addr), 0);
        chk("t6 rst busy", 32'(busy), 0);
        chk("t6 rst ch0_offset", 32'(ch0_offset), 0);
        tick(2);
        rst_n = 1;
        tick();
        line_strobe = 1; tick(); line_strobe = 0;
        chk("t6 addr ph0=0", 32'(rom_addr), 32'h200);
        tick();
        chk("t6 addr ph1=0", 32'(rom_addr), 32'h100);
        tick();
        chk("t6 ch0_offset neg", 32'(ch0_offset), 32'h103);
        tick();
        chk("t6 ch1_offset", 32'(ch1_offset), 32'h003);
        tick(3);

        chk_on = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
